// File: rtl/aim_instr_decoder_pkg.sv
// aim_isa_pkg: AIM instruction field positions, default class codes and decoded field bundle
package aim_isa_pkg;
  localparam int CLASS_MSB = 31;
  localparam int CLASS_LSB = 28;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int TYPE_MSB = 27;
  localparam int TYPE_LSB = 24;
  localparam int SRC_MSB = 23;
  localparam int SRC_LSB = 16;
  localparam int DST_MSB = 15;
  localparam int DST_LSB = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;
  localparam logic [3:0] AI_CLASS_DEF = 4'h1;
  localparam logic [3:0] GFX_CLASS_DEF = 4'h2;
  typedef struct packed {
    logic [5:0] opcode;
    logic [3:0] ai_type;
    logic [3:0] gfx_type;
    logic [7:0] src_reg;
    logic [7:0] dst_reg;
    logic [7:0] imm;
  } dec_fields_t;
endpackage

// File: rtl/aim_instr_decoder_if.sv
// aim_instr_decoder_if: fetch-to-decoder bus; illegal signal present only with AIM_DEC_ILLEGAL_EN
interface aim_instr_decoder_if;
  logic in_valid;
  logic [31:0] instr;
  logic out_valid;
  logic is_ai;
  logic is_graphics;
  logic [5:0] opcode;
  logic [3:0] ai_type;
  logic [3:0] gfx_type;
  logic [7:0] src_reg;
  logic [7:0] dst_reg;
  logic [7:0] imm;
`ifdef AIM_DEC_ILLEGAL_EN
  logic illegal;
  modport master (output in_valid, instr,
                  input out_valid, is_ai, is_graphics, opcode, ai_type, gfx_type, src_reg, dst_reg, imm, illegal);
  modport slave (input in_valid, instr,
                 output out_valid, is_ai, is_graphics, opcode, ai_type, gfx_type, src_reg, dst_reg, imm, illegal);
`else
  modport master (output in_valid, instr,
                  input out_valid, is_ai, is_graphics, opcode, ai_type, gfx_type, src_reg, dst_reg, imm);
  modport slave (input in_valid, instr,
                 output out_valid, is_ai, is_graphics, opcode, ai_type, gfx_type, src_reg, dst_reg, imm);
`endif
endinterface

// File: rtl/aim_instr_decoder_field_extract.sv
// aim_field_extract: combinational split of an AIM word into fields and class flags
module aim_field_extract
  import aim_isa_pkg::*;
#(
  parameter logic [3:0] AI_CLASS = AI_CLASS_DEF,
  parameter logic [3:0] GFX_CLASS = GFX_CLASS_DEF
) (
  input  logic [31:0] instr,
  output dec_fields_t fields,
  output logic        is_ai,
  output logic        is_graphics
);
  logic [3:0] cls;
  logic [3:0] typ;
  always_comb begin
    cls = instr[CLASS_MSB:CLASS_LSB];
    typ = instr[TYPE_MSB:TYPE_LSB];
    is_ai = cls == AI_CLASS;
    is_graphics = cls == GFX_CLASS;
    fields.opcode = instr[OPC_MSB:OPC_LSB];
    fields.ai_type = is_ai ? typ : '0;
    fields.gfx_type = is_graphics ? typ : '0;
    fields.src_reg = instr[SRC_MSB:SRC_LSB];
    fields.dst_reg = instr[DST_MSB:DST_LSB];
    fields.imm = instr[IMM_MSB:IMM_LSB];
  end
endmodule

// File: rtl/aim_instr_decoder.sv
// aim_instr_decoder: one-stage registered AIM decoder; AIM_DEC_ILLEGAL_EN adds the illegal flag
module aim_instr_decoder
  import aim_isa_pkg::*;
#(
  parameter logic [3:0] AI_CLASS = AI_CLASS_DEF,
  parameter logic [3:0] GFX_CLASS = GFX_CLASS_DEF
) (
  input logic clk,
  input logic rst_n,
  aim_instr_decoder_if.slave bus
);
  if (AI_CLASS == GFX_CLASS) begin : g_class_clash
    $error("aim_instr_decoder: AI_CLASS and GFX_CLASS must differ");
  end
  dec_fields_t fields;
  dec_fields_t fields_q;
  logic is_ai;
  logic is_graphics;
  logic valid_q;
  logic is_ai_q;
  logic is_graphics_q;
  aim_field_extract #(.AI_CLASS(AI_CLASS), .GFX_CLASS(GFX_CLASS)) u_extract (
    .instr(bus.instr),
    .fields(fields),
    .is_ai(is_ai),
    .is_graphics(is_graphics)
  );
  // Fields hold across idle cycles; only the valid flag drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      is_ai_q <= 1'b0;
      is_graphics_q <= 1'b0;
      fields_q <= '0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        is_ai_q <= is_ai;
        is_graphics_q <= is_graphics;
        fields_q <= fields;
      end
    end
  end
`ifdef AIM_DEC_ILLEGAL_EN
  logic illegal_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else illegal_q <= bus.in_valid && !is_ai && !is_graphics;
  end
  assign bus.illegal = illegal_q;
`endif
  assign bus.out_valid = valid_q;
  assign bus.is_ai = is_ai_q;
  assign bus.is_graphics = is_graphics_q;
  assign bus.opcode = fields_q.opcode;
  assign bus.ai_type = fields_q.ai_type;
  assign bus.gfx_type = fields_q.gfx_type;
  assign bus.src_reg = fields_q.src_reg;
  assign bus.dst_reg = fields_q.dst_reg;
  assign bus.imm = fields_q.imm;
endmodule

// File: tb/tb_aim_instr_decoder.sv
// tb_aim_instr_decoder: directed checks of the AIM decoder (honours AIM_DEC_ILLEGAL_EN)
module tb_aim_instr_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  aim_instr_decoder_if bus();
  aim_instr_decoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic ai, input logic gfx,
                         input logic [5:0] opc, input logic [3:0] at, input logic [3:0] gt,
                         input logic [7:0] s, input logic [7:0] d, input logic [7:0] i,
                         input logic ill);
    chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    chk({tag, ".is_ai"}, {31'd0, bus.is_ai}, {31'd0, ai});
    chk({tag, ".is_graphics"}, {31'd0, bus.is_graphics}, {31'd0, gfx});
    chk({tag, ".opcode"}, {26'd0, bus.opcode}, {26'd0, opc});
    chk({tag, ".ai_type"}, {28'd0, bus.ai_type}, {28'd0, at});
    chk({tag, ".gfx_type"}, {28'd0, bus.gfx_type}, {28'd0, gt});
    chk({tag, ".src_reg"}, {24'd0, bus.src_reg}, {24'd0, s});
    chk({tag, ".dst_reg"}, {24'd0, bus.dst_reg}, {24'd0, d});
    chk({tag, ".imm"}, {24'd0, bus.imm}, {24'd0, i});
`ifdef AIM_DEC_ILLEGAL_EN
    chk({tag, ".illegal"}, {31'd0, bus.illegal}, {31'd0, ill});
`else
    if (ill) begin end
`endif
  endtask

  task automatic step(input logic v, input logic [31:0] w);
    bus.in_valid = v;
    bus.instr = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.instr = 32'hF1234567;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all("reset_hold", 0, 0, 0, 6'h00, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 0);
    #2 rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_reset_idle", 0, 0, 0, 6'h00, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 0);
    step(1, 32'h10A43211);
    chk_all("ai_word", 1, 1, 0, 6'h04, 4'h0, 4'h0, 8'hA4, 8'h32, 8'h11, 0);
    step(1, 32'h20B56788);
    chk_all("gfx_word", 1, 0, 1, 6'h08, 4'h0, 4'h0, 8'hB5, 8'h67, 8'h88, 0);
    step(1, 32'hF1234567);
    chk_all("other_word", 1, 0, 0, 6'h3C, 4'h0, 4'h0, 8'h23, 8'h45, 8'h67, 1);
    step(1, 32'h1F000000);
    chk_all("ai_type_f", 1, 1, 0, 6'h07, 4'hF, 4'h0, 8'h00, 8'h00, 8'h00, 0);
    step(0, 32'h20B56788);
    chk_all("idle_hold", 0, 1, 0, 6'h07, 4'hF, 4'h0, 8'h00, 8'h00, 8'h00, 0);
    step(1, 32'h2A000000);
    chk_all("gfx_type_a", 1, 0, 1, 6'h0A, 4'h0, 4'hA, 8'h00, 8'h00, 8'h00, 0);
    step(1, 32'h10A43211);
    chk_all("stream0", 1, 1, 0, 6'h04, 4'h0, 4'h0, 8'hA4, 8'h32, 8'h11, 0);
    step(1, 32'h20B56788);
    chk_all("stream1", 1, 0, 1, 6'h08, 4'h0, 4'h0, 8'hB5, 8'h67, 8'h88, 0);
    step(1, 32'hF1234567);
    chk_all("stream2", 1, 0, 0, 6'h3C, 4'h0, 4'h0, 8'h23, 8'h45, 8'h67, 1);
    step(1, 32'h10A43211);
    chk_all("pre_async", 1, 1, 0, 6'h04, 4'h0, 4'h0, 8'hA4, 8'h32, 8'h11, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 6'h00, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 0);
    @(posedge clk);
    #1;
    chk_all("reset_held", 0, 0, 0, 6'h00, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
